// File: rtl/id_ex_operand_stage_if.sv
// Decode/execute boundary bundle: decoded operands in, writeback
// forwarding sources in, registered operands and hazard flag out.
interface id_ex_operand_stage_if;
  logic        id_valid;
  logic [15:0] id_rs_val;
  logic [15:0] id_rt_val;
  logic [2:0]  id_rs_idx;
  logic [2:0]  id_rt_idx;
  logic        id_rs_used;
  logic        id_rt_used;
  logic [15:0] id_imm;
  logic        id_use_imm;
  logic [1:0]  id_op;
  logic        id_cin;
  logic        id_wr_en;
  logic [2:0]  id_wr_idx;
  logic        id_is_load;
  logic        exm_wr_en;
  logic [2:0]  exm_wr_idx;
  logic [15:0] exm_result;
  logic        mwb_wr_en;
  logic [2:0]  mwb_wr_idx;
  logic [15:0] mwb_result;
  logic        stall;
  logic        flush;
  logic        load_use;
  logic        ex_valid;
  logic [15:0] ex_in_a;
  logic [15:0] ex_b;
  logic        ex_cin;
  logic [1:0]  ex_op;
  logic        ex_wr_en;
  logic [2:0]  ex_wr_idx;
  logic        ex_is_load;

  modport master (
    output id_valid, id_rs_val, id_rt_val, id_rs_idx, id_rt_idx, id_rs_used,
           id_rt_used, id_imm, id_use_imm, id_op, id_cin, id_wr_en, id_wr_idx,
           id_is_load, exm_wr_en, exm_wr_idx, exm_result, mwb_wr_en,
           mwb_wr_idx, mwb_result, stall, flush,
    input  load_use, ex_valid, ex_in_a, ex_b, ex_cin, ex_op, ex_wr_en,
           ex_wr_idx, ex_is_load
  );

  modport slave (
    input  id_valid, id_rs_val, id_rt_val, id_rs_idx, id_rt_idx, id_rs_used,
           id_rt_used, id_imm, id_use_imm, id_op, id_cin, id_wr_en, id_wr_idx,
           id_is_load, exm_wr_en, exm_wr_idx, exm_result, mwb_wr_en,
           mwb_wr_idx, mwb_result, stall, flush,
    output load_use, ex_valid, ex_in_a, ex_b, ex_cin, ex_op, ex_wr_en,
           ex_wr_idx, ex_is_load
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the 16-bit logic/add unit. Holds decoded
// operands, forwards EX/MEM and MEM/WB results onto the outgoing operands,
// inserts a bubble on load-use hazards and honours stall/flush.
module id_ex_operand_stage (
  input  logic                   clk,
  input  logic                   rst_n,
  id_ex_operand_stage_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_next;
  logic [15:0] rs_val, rs_val_next;
  logic [15:0] rt_val, rt_val_next;
  logic [15:0] imm, imm_next;
  logic        use_imm, use_imm_next;
  logic [2:0]  rs_idx, rs_idx_next;
  logic [2:0]  rt_idx, rt_idx_next;
  logic        rs_used, rs_used_next;
  logic        rt_used, rt_used_next;
  logic [1:0]  op, op_next;
  logic        cin, cin_next;
  logic        wr_en, wr_en_next;
  logic [2:0]  wr_idx, wr_idx_next;
  logic        is_load, is_load_next;

  logic        valid;
  logic [15:0] fwd_rs;
  logic [15:0] fwd_rt;
  logic        load_use;

  assign valid = (state == FULL);

  // rs operand bypass: newest writer (EX/MEM) beats older (MEM/WB)
  always_comb begin
    fwd_rs = rs_val;
    if (rs_used && bus.exm_wr_en && (bus.exm_wr_idx == rs_idx))
      fwd_rs = bus.exm_result;
    else if (rs_used && bus.mwb_wr_en && (bus.mwb_wr_idx == rs_idx))
      fwd_rs = bus.mwb_result;
  end

  // rt operand bypass, same priority as rs
  always_comb begin
    fwd_rt = rt_val;
    if (rt_used && bus.exm_wr_en && (bus.exm_wr_idx == rt_idx))
      fwd_rt = bus.exm_result;
    else if (rt_used && bus.mwb_wr_en && (bus.mwb_wr_idx == rt_idx))
      fwd_rt = bus.mwb_result;
  end

  // A load sitting here cannot forward yet, so a dependent decode must wait
  assign load_use = bus.id_valid && valid && is_load && wr_en &&
                    ((bus.id_rs_used && (bus.id_rs_idx == wr_idx)) ||
                     (bus.id_rt_used && !bus.id_use_imm && (bus.id_rt_idx == wr_idx)));

  // Next-state selection: flush, then stall, then bubble, then capture
  always_comb begin
    state_next   = state;
    rs_val_next  = rs_val;
    rt_val_next  = rt_val;
    imm_next     = imm;
    use_imm_next = use_imm;
    rs_idx_next  = rs_idx;
    rt_idx_next  = rt_idx;
    rs_used_next = rs_used;
    rt_used_next = rt_used;
    op_next      = op;
    cin_next     = cin;
    wr_en_next   = wr_en;
    wr_idx_next  = wr_idx;
    is_load_next = is_load;
    if (bus.flush) begin
      state_next   = EMPTY;
      wr_en_next   = 1'b0;
      is_load_next = 1'b0;
    end else if (bus.stall) begin
      rs_val_next = fwd_rs;
      rt_val_next = fwd_rt;
    end else if (load_use) begin
      state_next   = EMPTY;
      wr_en_next   = 1'b0;
      is_load_next = 1'b0;
    end else begin
      state_next   = bus.id_valid ? FULL : EMPTY;
      rs_val_next  = bus.id_rs_val;
      rt_val_next  = bus.id_rt_val;
      imm_next     = bus.id_imm;
      use_imm_next = bus.id_use_imm;
      rs_idx_next  = bus.id_rs_idx;
      rt_idx_next  = bus.id_rt_idx;
      rs_used_next = bus.id_rs_used;
      rt_used_next = bus.id_rt_used;
      op_next      = bus.id_op;
      cin_next     = bus.id_cin;
      wr_en_next   = bus.id_wr_en;
      wr_idx_next  = bus.id_wr_idx;
      is_load_next = bus.id_is_load;
    end
  end

  // State register (EMPTY/FULL)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Operand and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_val  <= '0;
      rt_val  <= '0;
      imm     <= '0;
      use_imm <= 1'b0;
      rs_idx  <= '0;
      rt_idx  <= '0;
      rs_used <= 1'b0;
      rt_used <= 1'b0;
      op      <= '0;
      cin     <= 1'b0;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      is_load <= 1'b0;
    end else begin
      rs_val  <= rs_val_next;
      rt_val  <= rt_val_next;
      imm     <= imm_next;
      use_imm <= use_imm_next;
      rs_idx  <= rs_idx_next;
      rt_idx  <= rt_idx_next;
      rs_used <= rs_used_next;
      rt_used <= rt_used_next;
      op      <= op_next;
      cin     <= cin_next;
      wr_en   <= wr_en_next;
      wr_idx  <= wr_idx_next;
      is_load <= is_load_next;
    end
  end

  assign bus.load_use   = load_use;
  assign bus.ex_valid   = valid;
  assign bus.ex_in_a    = fwd_rs;
  assign bus.ex_b       = use_imm ? imm : fwd_rt;
  assign bus.ex_cin     = cin;
  assign bus.ex_op      = op;
  assign bus.ex_wr_en   = wr_en && valid;
  assign bus.ex_wr_idx  = wr_idx;
  assign bus.ex_is_load = is_load;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: a scoreboard queue holds the
// expected stage outputs for each driven step; tasks pop and compare them.
module tb_id_ex_operand_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] in_a;
    logic [15:0] b;
    logic        cin;
    logic [1:0]  op;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic        is_load;
    logic        load_use;
  } obs_t;

  typedef struct packed {
    obs_t val;
    obs_t mask;
  } sb_t;

  sb_t  sb[$];
  obs_t full_mask;
  obs_t ctrl_mask;

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic obs_t mk_obs(input logic v, input logic [15:0] a,
                                  input logic [15:0] b, input logic c,
                                  input logic [1:0] o, input logic we,
                                  input logic [2:0] wi, input logic ld,
                                  input logic lu);
    obs_t r;
    r.valid = v; r.in_a = a; r.b = b; r.cin = c; r.op = o;
    r.wr_en = we; r.wr_idx = wi; r.is_load = ld; r.load_use = lu;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.valid = bus.ex_valid; r.in_a = bus.ex_in_a; r.b = bus.ex_b;
    r.cin = bus.ex_cin; r.op = bus.ex_op; r.wr_en = bus.ex_wr_en;
    r.wr_idx = bus.ex_wr_idx; r.is_load = bus.ex_is_load;
    r.load_use = bus.load_use;
    return r;
  endfunction

  task automatic clear_all();
    bus.id_valid = 0; bus.id_rs_val = 0; bus.id_rt_val = 0;
    bus.id_rs_idx = 0; bus.id_rt_idx = 0; bus.id_rs_used = 0;
    bus.id_rt_used = 0; bus.id_imm = 0; bus.id_use_imm = 0; bus.id_op = 0;
    bus.id_cin = 0; bus.id_wr_en = 0; bus.id_wr_idx = 0; bus.id_is_load = 0;
    bus.exm_wr_en = 0; bus.exm_wr_idx = 0; bus.exm_result = 0;
    bus.mwb_wr_en = 0; bus.mwb_wr_idx = 0; bus.mwb_result = 0;
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic drive_id(input logic v, input logic [15:0] rsv,
                          input logic [15:0] rtv, input logic [2:0] rsi,
                          input logic [2:0] rti, input logic rsu,
                          input logic rtu, input logic [15:0] im,
                          input logic ui, input logic [1:0] o, input logic c,
                          input logic we, input logic [2:0] wi,
                          input logic ld);
    bus.id_valid = v; bus.id_rs_val = rsv; bus.id_rt_val = rtv;
    bus.id_rs_idx = rsi; bus.id_rt_idx = rti; bus.id_rs_used = rsu;
    bus.id_rt_used = rtu; bus.id_imm = im; bus.id_use_imm = ui;
    bus.id_op = o; bus.id_cin = c; bus.id_wr_en = we; bus.id_wr_idx = wi;
    bus.id_is_load = ld;
  endtask

  task automatic test_reset();
    sb_t e; obs_t got;
    sb.push_back('{val: mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0), mask: full_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL reset_initial: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_id(1, 16'h1234, 16'h0F0F, 3'd1, 3'd2, 1, 1, 16'h0, 0, 2'b00, 1, 1, 3'd5, 0);
    sb.push_back('{val: mk_obs(1, 16'h1234, 16'h0F0F, 1, 2'b00, 1, 3'd5, 0, 0), mask: full_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL capture_add: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    bus.stall = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.push_back('{val: mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0), mask: full_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL reset_mid_stall: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    sb.push_back('{val: mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0), mask: full_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL reset_held: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    clear_all();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    sb_t e; obs_t got;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] rsv, rtv, im;
      logic [2:0]  rsi, rti;
      logic        v, ui, c, rsu;
      logic [1:0]  o;
      rsv = 16'($urandom); rtv = 16'($urandom); im = 16'($urandom);
      rsi = 3'($urandom); rti = 3'($urandom); rsu = 1'($urandom);
      v = (i != 3); ui = i[0]; o = i[1:0]; c = i[2];
      @(negedge clk);
      drive_id(v, rsv, rtv, rsi, rti, rsu, 1, im, ui, o, c, 1, 3'(i), 0);
      sb.push_back('{val: mk_obs(v, rsv, ui ? im : rtv, c, o, v, 3'(i), 0, 0), mask: full_mask});
      @(posedge clk); #1;
      e = sb.pop_front(); got = sample(); checks++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        failures++; $display("[TB] FAIL back_to_back[%0d]: got=%h want=%h", i, got & e.mask, e.val & e.mask);
      end
    end
    @(negedge clk);
    clear_all();
  endtask

  task automatic test_forward();
    sb_t e; obs_t got;
    @(negedge clk);
    drive_id(1, 16'h0000, 16'h7777, 3'd3, 3'd3, 1, 0, 16'h0, 0, 2'b01, 0, 1, 3'd6, 0);
    @(posedge clk); #1;
    bus.exm_wr_en = 1; bus.exm_wr_idx = 3'd3; bus.exm_result = 16'hAAAA;
    bus.mwb_wr_en = 1; bus.mwb_wr_idx = 3'd3; bus.mwb_result = 16'h5555;
    sb.push_back('{val: mk_obs(1, 16'hAAAA, 16'h7777, 0, 2'b01, 1, 3'd6, 0, 0), mask: full_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL fwd_exm_priority: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    bus.exm_wr_en = 0;
    sb.push_back('{val: mk_obs(1, 16'h5555, 16'h7777, 0, 2'b01, 1, 3'd6, 0, 0), mask: full_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL fwd_mwb: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    bus.exm_wr_en = 1; bus.exm_wr_idx = 3'd4;
    sb.push_back('{val: mk_obs(1, 16'h5555, 16'h7777, 0, 2'b01, 1, 3'd6, 0, 0), mask: full_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL fwd_exm_idx_miss: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    bus.mwb_wr_en = 0;
    sb.push_back('{val: mk_obs(1, 16'h0000, 16'h7777, 0, 2'b01, 1, 3'd6, 0, 0), mask: full_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL fwd_none: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    clear_all();
  endtask

  task automatic test_immediate();
    sb_t e; obs_t got;
    @(negedge clk);
    drive_id(1, 16'h0101, 16'h2222, 3'd1, 3'd2, 0, 1, 16'hFFF0, 1, 2'b10, 0, 0, 3'd0, 0);
    bus.exm_wr_en = 1; bus.exm_wr_idx = 3'd2; bus.exm_result = 16'h1111;
    sb.push_back('{val: mk_obs(1, 16'h0101, 16'hFFF0, 0, 2'b10, 0, 3'd0, 0, 0), mask: full_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL imm_beats_fwd: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    bus.id_use_imm = 0;
    sb.push_back('{val: mk_obs(1, 16'h0101, 16'h1111, 0, 2'b10, 0, 3'd0, 0, 0), mask: full_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL rt_fwd_exm: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    clear_all();
  endtask

  task automatic test_load_use();
    sb_t e; obs_t got;
    @(negedge clk);
    drive_id(1, 16'h4000, 16'h0044, 3'd0, 3'd0, 0, 0, 16'h0, 0, 2'b00, 0, 1, 3'd4, 1);
    @(posedge clk); #1;
    drive_id(1, 16'hDEAD, 16'h0000, 3'd4, 3'd0, 1, 0, 16'h0, 0, 2'b00, 0, 1, 3'd5, 0);
    sb.push_back('{val: mk_obs(1, 16'h4000, 16'h0044, 0, 2'b00, 1, 3'd4, 1, 1), mask: full_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL load_use_rs: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    sb.push_back('{val: mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0), mask: ctrl_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL bubble_after_load_use: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    drive_id(1, 16'h4000, 16'h0044, 3'd0, 3'd0, 0, 0, 16'h0, 0, 2'b00, 0, 1, 3'd4, 1);
    @(posedge clk); #1;
    drive_id(1, 16'h0000, 16'h0000, 3'd0, 3'd4, 0, 1, 16'h0008, 1, 2'b00, 0, 1, 3'd5, 0);
    sb.push_back('{val: mk_obs(1, 0, 0, 0, 0, 1, 0, 1, 0), mask: ctrl_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL no_hazard_imm: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    bus.id_use_imm = 0;
    sb.push_back('{val: mk_obs(1, 0, 0, 0, 0, 1, 0, 1, 1), mask: ctrl_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL load_use_rt: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    bus.id_valid = 0;
    sb.push_back('{val: mk_obs(1, 0, 0, 0, 0, 1, 0, 1, 0), mask: ctrl_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL no_hazard_invalid: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    bus.id_valid = 1; bus.stall = 1;
    sb.push_back('{val: mk_obs(1, 16'h4000, 16'h0044, 0, 2'b00, 1, 3'd4, 1, 1), mask: full_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL stall_over_load_use: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    bus.stall = 0;
    sb.push_back('{val: mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0), mask: ctrl_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL bubble_after_stall: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    clear_all();
  endtask

  task automatic test_stall_retention();
    sb_t e; obs_t got;
    @(negedge clk);
    drive_id(1, 16'h0000, 16'h0F00, 3'd1, 3'd0, 1, 0, 16'h0, 0, 2'b10, 1, 1, 3'd7, 0);
    @(posedge clk);
    @(negedge clk);
    bus.stall = 1;
    bus.mwb_wr_en = 1; bus.mwb_wr_idx = 3'd1; bus.mwb_result = 16'h00C3;
    drive_id(1, 16'hBEEF, 16'h1234, 3'd2, 3'd3, 1, 1, 16'h0, 0, 2'b11, 0, 1, 3'd2, 0);
    @(posedge clk); #1;
    bus.mwb_wr_en = 0;
    sb.push_back('{val: mk_obs(1, 16'h00C3, 16'h0F00, 1, 2'b10, 1, 3'd7, 0, 0), mask: full_mask});
    #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL stall_retains_fwd: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    bus.stall = 0;
    sb.push_back('{val: mk_obs(1, 16'hBEEF, 16'h1234, 0, 2'b11, 1, 3'd2, 0, 0), mask: full_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL release_capture: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    clear_all();
  endtask

  task automatic test_flush();
    sb_t e; obs_t got;
    @(negedge clk);
    drive_id(1, 16'h5555, 16'h6666, 3'd0, 3'd0, 0, 0, 16'h0, 0, 2'b01, 0, 1, 3'd3, 1);
    sb.push_back('{val: mk_obs(1, 0, 0, 0, 0, 1, 0, 1, 0), mask: ctrl_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL flush_setup: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    bus.flush = 1; bus.stall = 1;
    sb.push_back('{val: mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0), mask: ctrl_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL flush_over_stall: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    bus.flush = 0; bus.stall = 0;
    sb.push_back('{val: mk_obs(1, 0, 0, 0, 0, 1, 0, 1, 0), mask: ctrl_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL refill_after_flush: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    bus.flush = 1;
    sb.push_back('{val: mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 0), mask: ctrl_mask});
    @(posedge clk); #1;
    e = sb.pop_front(); got = sample(); checks++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      failures++; $display("[TB] FAIL flush_over_capture: got=%h want=%h", got & e.mask, e.val & e.mask);
    end
    @(negedge clk);
    clear_all();
  endtask

  // Test sequence
  initial begin
    checks = 0;
    failures = 0;
    full_mask = '1;
    ctrl_mask = '0;
    ctrl_mask.valid = 1'b1; ctrl_mask.wr_en = 1'b1;
    ctrl_mask.is_load = 1'b1; ctrl_mask.load_use = 1'b1;
    clear_all();
    rst_n = 1'b0;
    #12;
    test_reset();
    test_back_to_back();
    test_forward();
    test_immediate();
    test_load_use();
    test_stall_retention();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
